// File: rtl/freq_counter_pkg.sv
// Shared constants for the frequency counter display path.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package freq_counter_pkg;

   localparam int unsigned NUM_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-BCD codes show a dash so a corrupt digit is visible on the display.
module bcd_to_7seg
   import freq_counter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Latches eight BCD digits on load and scans them onto a common-anode
// seven-segment display, one digit per REFRESH_DIV cycles, with optional leading-zero blanking.
module bcd_display_scan
   import freq_counter_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       blank_lz,
   input  logic [3:0] one,
   input  logic [3:0] ten,
   input  logic [3:0] hundred,
   input  logic [3:0] thousands,
   input  logic [3:0] ten_thousands,
   input  logic [3:0] hundred_thousands,
   input  logic [3:0] millions,
   input  logic [3:0] ten_millions,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [3:0]       shadow_q [NUM_DIGITS];
   logic [3:0]       din      [NUM_DIGITS];
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             tick;
   logic             lz_blank;
   logic             upper_zero;
   logic [6:0]       cur_seg;

   assign din[0] = one;
   assign din[1] = ten;
   assign din[2] = hundred;
   assign din[3] = thousands;
   assign din[4] = ten_thousands;
   assign din[5] = hundred_thousands;
   assign din[6] = millions;
   assign din[7] = ten_millions;

   assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

   bcd_to_7seg u_dec (
      .bcd (shadow_q[idx_q]),
      .seg (cur_seg)
   );

   // Digit i is a leading zero when it and every more-significant digit is zero.
   always_comb begin
      lz_blank   = 1'b0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (shadow_q[i] == 4'd0);
         if (idx_q == 3'(i)) lz_blank = upper_zero;
      end
   end

   always_comb begin
      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         if (blank_lz && lz_blank) begin
            an_d  = 8'hFF;
            seg_d = SEG_BLANK;
         end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = cur_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
         an_q  <= 8'hFF;
         seg_q <= SEG_BLANK;
         for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= 4'd0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
         if (tick) idx_q <= idx_q + 3'd1;
         an_q  <= an_d;
         seg_q <= seg_d;
         if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= din[i];
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with a slot-level reference model
// (cycle count modulo REFRESH_DIV, digit table lookup, highest-non-zero-digit blanking).
module tb_bcd_display_scan;

   localparam int unsigned DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic       blank_lz = 1'b0;
   logic [3:0] d [8];
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         cyc;
   int         slot_n;
   logic [3:0] sh [8];
   logic [7:0] exp_an;
   logic [6:0] exp_seg;
   logic [6:0] seg_tab [16];

   always #5 clk = ~clk;

   bcd_display_scan #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .load              (load),
      .blank_lz          (blank_lz),
      .one               (d[0]),
      .ten               (d[1]),
      .hundred           (d[2]),
      .thousands         (d[3]),
      .ten_thousands     (d[4]),
      .hundred_thousands (d[5]),
      .millions          (d[6]),
      .ten_millions      (d[7]),
      .an                (an),
      .seg               (seg),
      .dp                (dp)
   );

   // Advance one clock, update the model from the inputs held across the edge.
   task automatic step();
      int hi;
      int i;
      @(posedge clk);
      if (rst) begin
         cyc = 0; slot_n = 0; exp_an = 8'hFF; exp_seg = 7'h7F;
         for (int k = 0; k < 8; k++) sh[k] = 4'd0;
      end else begin
         cyc++;
         if (cyc % DIV == 0) begin
            i  = slot_n % 8;
            hi = -1;
            for (int k = 0; k < 8; k++) if (sh[k] != 4'd0) hi = k;
            if (blank_lz && i > 0 && i > hi) begin
               exp_an = 8'hFF; exp_seg = 7'h7F;
            end else begin
               exp_an = 8'hFF; exp_an[i] = 1'b0;
               exp_seg = seg_tab[sh[i]];
            end
            slot_n++;
         end
         if (load) for (int k = 0; k < 8; k++) sh[k] = d[k];
      end
      #1;
   endtask

   task automatic set_value(input int v);
      int t = v;
      for (int k = 0; k < 8; k++) begin
         d[k] = 4'(t % 10);
         t    = t / 10;
      end
   endtask

   task automatic do_load();
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) step();
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_hold: an=%h seg=%h dp=%b, want an=ff seg=7f dp=1", an, seg, dp);
      end
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (k < 4 && an !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pre_tick cyc%0d: an=%h want ff", k, an);
         end else if (k == 4 && (an !== 8'hFE || seg !== 7'h40)) begin
            errors++;
            $display("FAIL reset_first_tick: an=%h seg=%h want an=fe seg=40", an, seg);
         end
      end
   endtask

   // Run n cycles comparing every cycle against the model.
   task automatic test_scan(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         checks++;
         if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s cyc%0d slot%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                     name, k, slot_n, an, seg, dp, exp_an, exp_seg);
         end
      end
   endtask

   task automatic align_to_index0();
      int guard = 0;
      while (!((cyc + 1) % DIV == 0 && slot_n % 8 == 0) && guard < 100) begin
         step(); guard++;
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL align_timeout: guard=%0d want <100", guard);
      end
   endtask

   task automatic test_blank_7891();
      set_value(7891); blank_lz = 1'b1;
      do_load();
      align_to_index0();
      test_scan("blank_7891", 8 * DIV);
      // Explicit digit-3 slot: after 3 more ticks from index 0.
      align_to_index0();
      for (int k = 0; k < 4 * DIV; k++) step();
      checks++;
      if (an !== 8'hF7 || seg !== 7'h78) begin
         errors++;
         $display("FAIL blank_7891_slot3: an=%h seg=%h want an=f7 seg=78", an, seg);
      end
      for (int k = 0; k < DIV; k++) step();
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F) begin
         errors++;
         $display("FAIL blank_7891_slot4: an=%h seg=%h want an=ff seg=7f", an, seg);
      end
   endtask

   task automatic test_noblank();
      blank_lz = 1'b0;
      align_to_index0();
      test_scan("noblank_7891", 8 * DIV);
      align_to_index0();
      for (int k = 0; k < 8 * DIV; k++) step();
      checks++;
      if (an !== 8'h7F || seg !== 7'h40) begin
         errors++;
         $display("FAIL noblank_slot7: an=%h seg=%h want an=7f seg=40", an, seg);
      end
   endtask

   task automatic test_zero();
      set_value(0); blank_lz = 1'b1;
      do_load();
      align_to_index0();
      test_scan("zero_blank", 8 * DIV);
   endtask

   task automatic test_invalid();
      set_value(9999999); d[2] = 4'hA; blank_lz = 1'b1;
      do_load();
      align_to_index0();
      test_scan("invalid_nibble", 8 * DIV);
      align_to_index0();
      for (int k = 0; k < 3 * DIV; k++) step();
      checks++;
      if (an !== 8'hFB || seg !== 7'h3F) begin
         errors++;
         $display("FAIL invalid_slot2: an=%h seg=%h want an=fb seg=3f", an, seg);
      end
   endtask

   task automatic test_load_on_tick();
      logic [6:0] old_seg;
      set_value(3); blank_lz = 1'b0;
      do_load();
      align_to_index0();
      old_seg = 7'h30;
      d[0] = 4'd5;
      load = 1'b1;
      step();
      load = 1'b0;
      checks++;
      if (an !== 8'hFE || seg !== old_seg) begin
         errors++;
         $display("FAIL load_on_tick_old: an=%h seg=%h want an=fe seg=%h", an, seg, old_seg);
      end
      test_scan("load_on_tick", 8 * DIV);
      checks++;
      if (an !== 8'hFE || seg !== 7'h12) begin
         errors++;
         $display("FAIL load_on_tick_new: an=%h seg=%h want an=fe seg=12", an, seg);
      end
   endtask

   task automatic test_reset_midscan();
      int guard = 0;
      while (!(slot_n % 8 == 6 && cyc % DIV == 2) && guard < 100) begin
         step(); guard++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || guard >= 100) begin
         errors++;
         $display("FAIL reset_midscan: an=%h seg=%h guard=%0d want an=ff seg=7f", an, seg, guard);
      end
      for (int k = 0; k < DIV; k++) step();
      checks++;
      if (an !== 8'hFE || seg !== 7'h40) begin
         errors++;
         $display("FAIL reset_restart: an=%h seg=%h want an=fe seg=40", an, seg);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 9) == 0) d[k] = 4'($urandom_range(10, 15));
            else if ($urandom_range(0, 2) == 0) d[k] = 4'd0;
            else d[k] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 1) == 0) for (int k = 7; k >= $urandom_range(1, 7); k--) d[k] = 4'd0;
         blank_lz = 1'($urandom_range(0, 1));
         load = 1'($urandom_range(0, 1));
         test_scan("random", 1);
         load = 1'($urandom_range(0, 3) == 0);
         test_scan("random", int'($urandom_range(1, 3 * DIV)));
         load = 1'b0;
         test_scan("random", 10 * DIV);
      end
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      for (int k = 0; k < 8; k++) d[k] = 4'd0;
      cyc = 0; slot_n = 0; exp_an = 8'hFF; exp_seg = 7'h7F;
      for (int k = 0; k < 8; k++) sh[k] = 4'd0;
      #1;
      test_reset();
      test_blank_7891();
      test_noblank();
      test_zero();
      test_invalid();
      test_load_on_tick();
      test_reset_midscan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
